// File: rtl/pwm_gen_pkg.sv
// Shared types and default widths for the center-aligned PWM generator.
// Used by pwm_gen and pwm_deadband.
package pwm_gen_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int DT_W_DEF  = 8;

  typedef enum logic {
    UP,
    DOWN
  } dir_e;

  typedef enum logic [1:0] {
    IDLE_L,
    DEAD_TO_H,
    ON_H,
    DEAD_TO_L
  } db_state_e;

endpackage

// File: rtl/pwm_deadband.sv
// Complementary gate driver with dead band between high-side and low-side turn-on.
// PWM_DEADTIME_EN selects the dead-band FSM; otherwise a plain registered bypass.
module pwm_deadband
  import pwm_gen_pkg::*;
#(
  parameter int DT_W     = DT_W_DEF,
  parameter int DEADTIME = 25
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic enable,
  input  logic raw,
  output logic pwm_h,
  output logic pwm_l
);

  logic pwm_h_q, pwm_h_d;
  logic pwm_l_q, pwm_l_d;

`ifdef PWM_DEADTIME_EN
  localparam logic [DT_W-1:0] DT_LIM = DT_W'(DEADTIME);
  localparam logic [DT_W-1:0] DT_ONE = DT_W'(1);

  db_state_e       state_q, state_d;
  logic [DT_W-1:0] dt_q, dt_d;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE_L;
      dt_q    <= '0;
      pwm_h_q <= 1'b0;
      pwm_l_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dt_q    <= dt_d;
      pwm_h_q <= pwm_h_d;
      pwm_l_q <= pwm_l_d;
    end
  end

  // Every raw change restarts the dead counter toward the new level.
  always_comb begin
    state_d = state_q;
    dt_d    = dt_q;
    if (!enable) begin
      state_d = IDLE_L;
      dt_d    = '0;
    end else begin
      unique case (state_q)
        IDLE_L: begin
          if (raw) begin
            state_d = (DEADTIME == 0) ? ON_H : DEAD_TO_H;
            dt_d    = DT_ONE;
          end
        end
        DEAD_TO_H: begin
          if (!raw) begin
            state_d = DEAD_TO_L;
            dt_d    = DT_ONE;
          end else if (dt_q >= DT_LIM) begin
            state_d = ON_H;
          end else begin
            dt_d = dt_q + DT_ONE;
          end
        end
        ON_H: begin
          if (!raw) begin
            state_d = (DEADTIME == 0) ? IDLE_L : DEAD_TO_L;
            dt_d    = DT_ONE;
          end
        end
        DEAD_TO_L: begin
          if (raw) begin
            state_d = DEAD_TO_H;
            dt_d    = DT_ONE;
          end else if (dt_q >= DT_LIM) begin
            state_d = IDLE_L;
          end else begin
            dt_d = dt_q + DT_ONE;
          end
        end
        default: begin
          state_d = IDLE_L;
          dt_d    = '0;
        end
      endcase
    end
  end

  always_comb begin
    pwm_h_d = enable && (state_d == ON_H);
    pwm_l_d = enable && (state_d == IDLE_L);
  end
`else
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      pwm_h_q <= 1'b0;
      pwm_l_q <= 1'b0;
    end else begin
      pwm_h_q <= pwm_h_d;
      pwm_l_q <= pwm_l_d;
    end
  end

  always_comb begin
    pwm_h_d = enable && raw;
    pwm_l_d = enable && !raw;
  end
`endif

  assign pwm_h = pwm_h_q;
  assign pwm_l = pwm_l_q;

endmodule

// File: rtl/pwm_gen.sv
// Center-aligned PWM: up/down counter, valley-synchronous double-buffered duty,
// compare, and gate driver (dead band when PWM_DEADTIME_EN is defined).
module pwm_gen
  import pwm_gen_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PERIOD   = 2500,
  parameter int DT_W     = DT_W_DEF,
  parameter int DEADTIME = 25
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             enable,
  input  logic [CNT_W-1:0] duty_data,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_h,
  output logic             pwm_l,
  output logic             period_tick,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] PEAK    = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  dir_e             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic             tick_q, tick_d;

  logic             valley;
  logic             accept;
  logic             xfer;
  logic             raw;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      dir_q     <= UP;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      shadow_q  <= '0;
      active_q  <= '0;
      tick_q    <= 1'b0;
    end else begin
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      tick_q    <= tick_d;
    end
  end

  always_comb begin
    dir_d = dir_q;
    cnt_d = cnt_q;
    if (!enable) begin
      dir_d = UP;
      cnt_d = '0;
    end else begin
      unique case (dir_q)
        UP: begin
          if (cnt_q == PEAK) begin
            dir_d = DOWN;
            cnt_d = PEAK - CNT_ONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        DOWN: begin
          if (cnt_q == '0) begin
            dir_d = UP;
            cnt_d = CNT_ONE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          dir_d = UP;
          cnt_d = '0;
        end
      endcase
    end
  end

  // Shadow accepts only while empty; the valley transfer frees it, so the
  // two never coincide and a valley-cycle write waits for the next valley.
  always_comb begin
    valley    = enable && (cnt_q == '0);
    accept    = duty_valid && !pending_q;
    xfer      = valley && pending_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    active_d  = active_q;
    if (xfer) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (accept) begin
      shadow_d  = (duty_data > PEAK) ? PEAK : duty_data;
      pending_d = 1'b1;
    end
    tick_d = valley;
    raw    = (active_q == PEAK) || (cnt_q < active_q);
  end

  pwm_deadband #(
    .DT_W    (DT_W),
    .DEADTIME(DEADTIME)
  ) u_deadband (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .enable(enable),
    .raw   (raw),
    .pwm_h (pwm_h),
    .pwm_l (pwm_l)
  );

  assign duty_ready  = !pending_q;
  assign period_tick = tick_q;
  assign cnt         = cnt_q;

endmodule

// File: doc/pwm_gen.md
# pwm_gen

Center-aligned PWM generator directly downstream of the PI controller in the BLDC control path. It accepts duty-cycle words from the PI stage through a valid/ready handshake and double-buffers them so that updates take effect only at the counter valley. It drives a complementary high-side/low-side gate pair with optional dead-band. It also emits a once-per-period tick that the PI stage uses as its sampling trigger.

## Interface
- `CNT_W`, default 16: counter and duty width.
- `PERIOD`, default 2500: counter peak value; one PWM period is 2*PERIOD clocks.
- `DT_W`, default 8: dead-time counter width.
- `DEADTIME`, default 25: dead-band length in clocks; must be less than 2^DT_W.
- `ACLK` in 1: the single clock; everything is rising-edge.
- `ARESET` in 1: asynchronous, active-high reset.
- `enable` in 1: run the counter; when low, outputs are forced off.
- `duty_data` in CNT_W: unsigned duty in counts, from the PI controller.
- `duty_valid` in 1: `duty_data` is valid.
- `duty_ready` out 1: the shadow buffer is free.
- `pwm_h` out 1: high-side gate.
- `pwm_l` out 1: low-side gate.
- `period_tick` out 1: one-cycle pulse at the valley.
- `cnt` out CNT_W: current counter value, for debug and ADC trigger alignment.

## Operation
- **Counter:** two-state FSM, UP and DOWN.
  - Reset state: UP with cnt=0.
  - UP: cnt increments. At cnt==PERIOD it switches to DOWN, so the next value is PERIOD-1.
  - DOWN: cnt decrements. At cnt==0 it switches to UP, so the next value is 1.
  - The counter visits 0,1..PERIOD,PERIOD-1..1, which is 2*PERIOD clocks per period.
- **Duty buffer:** one-deep shadow register plus a `pending` flag.
  - `duty_ready` equals !pending.
  - On a handshake (valid and ready), shadow gets `duty_data` saturated to PERIOD, and pending is set.
  - In a cycle with cnt==0 and pending set, active gets shadow and pending clears. `duty_ready` rises the next cycle.
  - A handshake in the valley cycle itself loads the shadow only. It applies at the next valley; there is no bypass.
- **Compare:** raw = (cnt < active), except that active==PERIOD forces raw=1.
  - active=0 gives raw=0 permanently.
  - For 0<active<PERIOD, raw is high for 2*active-1 clocks per period.
- **period_tick:** registered and high for the single cycle after cnt==0. It is 0 while enable is low.
- **enable low:**
  - cnt is held at 0, state is UP, and `pwm_h`, `pwm_l` and `period_tick` are 0.
  - The dead-time logic is cleared.
  - The duty buffer keeps accepting writes and holds pending.
- **enable rising:** counting starts from 0 on the next clock, and the first valley transfer happens immediately if pending is set.
- **ARESET mid-operation:** every register returns to reset value asynchronously, including pending, which clears.

## Timing
- Reset values:
  - `pwm_h`=0, `pwm_l`=0, `period_tick`=0, `cnt`=0.
  - `duty_ready`=1.
  - active=0, shadow=0.
- raw is combinational from cnt and active. `pwm_h` and `pwm_l` are registered, so the minimum latency from a raw edge to an output change is 1 clock.
- **Raw rises:**
  - `pwm_l` falls 1 clock later.
  - `pwm_h` rises DEADTIME+1 clocks after the raw edge.
- **Raw falls:**
  - `pwm_h` falls 1 clock later.
  - `pwm_l` rises DEADTIME+1 clocks after the raw edge.
- A raw toggle during a dead band restarts the dead-time counter toward the new level. Both outputs stay low throughout.
- `pwm_h` and `pwm_l` are never high in the same cycle.
- **Handshake:**
  - The transfer completes in the cycle where valid and ready are both high.
  - `duty_data` need not be held afterwards.
  - valid may stay high across a ready-low interval; the data is accepted when ready returns.

## Configuration
- Macro: `PWM_DEADTIME_EN`.
- Defined: dead-band logic as specified above, with the `DEADTIME` and `DT_W` parameters active.
- Undefined:
  - `pwm_h` = raw, registered.
  - `pwm_l` = !raw, registered, except that it is 0 while enable is low.
  - Latency is 1 clock and there is no dead band.
  - `DEADTIME` and `DT_W` are ignored.

## Structure
- Shared package `pwm_gen_pkg` holds:
  - the counter-direction enum (UP, DOWN);
  - the dead-band state enum (IDLE_L, DEAD_TO_H, ON_H, DEAD_TO_L);
  - default `CNT_W` and `DT_W` constants.
- Sub-module `pwm_deadband` takes raw, enable, ACLK and ARESET and produces `pwm_h` and `pwm_l`. It is compiled into its bypass form when `PWM_DEADTIME_EN` is undefined.
- Counter, duty buffer and compare live in `pwm_gen`.

## Test plan
All scenarios use PERIOD=10 and DEADTIME=2, with `PWM_DEADTIME_EN` defined unless noted.
- **Reset and idle:** ARESET high, then enable=0 for 50 clocks.
  - Required: all outputs 0, `duty_ready`=1, cnt=0.
- **Steady duty:** write duty 5, enable=1.
  - Before the first valley transfer: `pwm_h` stays 0.
  - From the following period on, per 20-clock period: `pwm_h` high 7 clocks, `pwm_l` high 9 clocks, two 2-clock dead bands, `period_tick` every 20 clocks.
- **Buffering:** write 3 mid-period, then attempt 8 on the next clock.
  - Required: `duty_ready`=0 and 8 is not accepted until after the valley.
  - Active becomes 3 at the valley; 8 is accepted the cycle after and applies at the next valley.
- **Saturation and limits:**
  - duty 15: saturates to 10, giving `pwm_l`=0 and `pwm_h`=1 continuously after settling.
  - duty 0: `pwm_h`=0 and `pwm_l`=1 continuously.
- **Macro off:** same stimulus as steady duty 5.
  - Required: `pwm_h` high 9 clocks, `pwm_l` high 11 clocks, no both-low cycles while enabled.
- **Mid-run events:**
  - Drop enable at cnt=7 on DOWN: outputs are 0 next clock; on re-enable, cnt restarts from 0.
  - Assert ARESET asynchronously mid-period: outputs clear without waiting for ACLK, and pending clears.
